// File: rtl/dark_channel_ctrl_pkg.sv
// Shared constants, FSM state encoding and helpers for the dark-channel sequencer.
package dcp_pkg;

  localparam int unsigned DCP_DW    = 8;
  localparam int unsigned DCP_IMG_W = 640;
  localparam int unsigned DCP_IMG_H = 480;

  // Cycles from pixel acceptance to its registered dark-channel output.
  localparam int unsigned PIPE_LAT  = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } dcp_state_e;

  // Counter width able to hold 0..n-1.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dark_channel_ctrl_if.sv
// Stream/datapath bundle between the dark-channel sequencer and its neighbours.
interface dark_channel_ctrl_if
  import dcp_pkg::*;
#(
  parameter int unsigned DW = DCP_DW
);

  logic          in_valid;
  logic          in_sof;
  logic          shift_en;
  logic [DW-1:0] dark_in;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_sof;
  logic          out_eol;
  logic          frame_done;
  logic [DW-1:0] a_light;
  logic          sof_err;

  // Source side: pixel stream and datapath result in, filtered stream out.
  modport master (
    output in_valid, in_sof, dark_in,
    input  shift_en, out_valid, out_data, out_sof, out_eol,
           frame_done, a_light, sof_err
  );

  // Sequencer side.
  modport slave (
    input  in_valid, in_sof, dark_in,
    output shift_en, out_valid, out_data, out_sof, out_eol,
           frame_done, a_light, sof_err
  );

endinterface

// File: rtl/dark_channel_ctrl_raster_cnt.sv
// Raster x/y counter with wrap and per-pixel position flags for a 3x3 window.
module dcp_raster_cnt
  import dcp_pkg::*;
#(
  parameter int unsigned IMG_W = DCP_IMG_W,
  parameter int unsigned IMG_H = DCP_IMG_H
) (
  input  logic clk,
  input  logic rst_n,
  input  logic adv,          // current pixel accepted
  input  logic restart,      // current pixel is forced to (0,0)
  output logic at_origin,    // stored position is (0,0)
  output logic is_last,      // current pixel is (IMG_W-1, IMG_H-1)
  output logic is_interior,  // current pixel completes a 3x3 window
  output logic is_first_int, // current pixel is (2,2)
  output logic is_eol        // current pixel ends an interior output line
);

  localparam int unsigned XW = cnt_width(IMG_W);
  localparam int unsigned YW = cnt_width(IMG_H);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
  localparam logic [XW-1:0] X_TWO  = XW'(2);
  localparam logic [YW-1:0] Y_TWO  = YW'(2);

  logic [XW-1:0] x_q, x_d, cur_x;
  logic [YW-1:0] y_q, y_d, cur_y;

  // Position of the pixel presented this cycle and its classification.
  always_comb begin
    cur_x        = restart ? '0 : x_q;
    cur_y        = restart ? '0 : y_q;
    at_origin    = (x_q == '0) && (y_q == '0);
    is_interior  = (cur_x >= X_TWO) && (cur_y >= Y_TWO);
    is_first_int = (cur_x == X_TWO) && (cur_y == Y_TWO);
    is_eol       = is_interior && (cur_x == X_LAST);
    is_last      = (cur_x == X_LAST) && (cur_y == Y_LAST);
  end

  // Next expected position: advance on acceptance, wrap x then y.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (adv) begin
      if (cur_x == X_LAST) begin
        x_d = '0;
        y_d = (cur_y == Y_LAST) ? '0 : cur_y + 1'b1;
      end else begin
        x_d = cur_x + 1'b1;
        y_d = cur_y;
      end
    end
  end

  // Position registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

endmodule

// File: rtl/dark_channel_ctrl.sv
// Dark-channel sequencer: raster tracking, output qualification and
// per-frame atmospheric-light (max dark value) estimate.
module dark_channel_ctrl
  import dcp_pkg::*;
#(
  parameter int unsigned IMG_W = DCP_IMG_W,
  parameter int unsigned IMG_H = DCP_IMG_H,
  parameter int unsigned DW    = DCP_DW
) (
  input logic                sys_clk,
  input logic                sys_rst_n,
  dark_channel_ctrl_if.slave bus
);

  localparam logic [1:0] DRAIN_CAP = 2'(PIPE_LAT - 2);
  localparam logic [1:0] DRAIN_END = 2'(PIPE_LAT - 1);

  dcp_state_e    state_q, state_d;
  logic [1:0]    drain_q, drain_d;
  logic          started_q, started_d;
  logic [DW-1:0] max_run_q, max_run_d;
  logic [DW-1:0] pend_q, pend_d;
  logic [DW-1:0] a_light_q, a_light_d;
  logic          frame_done_q, frame_done_d;
  logic          sof_err_q, sof_err_d;
  logic          v1_q, v1_d;
  logic          sof1_q, sof1_d;
  logic          eol1_q, eol1_d;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          out_sof_q, out_sof_d;
  logic          out_eol_q, out_eol_d;

  logic          acc;
  logic          restart;
  logic [DW-1:0] max_upd;
  logic          at_origin, is_last, is_interior, is_first_int, is_eol;

  dcp_raster_cnt #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_cnt (
    .clk          (sys_clk),
    .rst_n        (sys_rst_n),
    .adv          (acc),
    .restart      (restart),
    .at_origin    (at_origin),
    .is_last      (is_last),
    .is_interior  (is_interior),
    .is_first_int (is_first_int),
    .is_eol       (is_eol)
  );

  assign bus.shift_en   = bus.in_valid;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_sof    = out_sof_q;
  assign bus.out_eol    = out_eol_q;
  assign bus.frame_done = frame_done_q;
  assign bus.a_light    = a_light_q;
  assign bus.sof_err    = sof_err_q;

  // Pixel acceptance: outside a frame only a start-of-frame pixel counts.
  always_comb begin
    unique case (state_q)
      IDLE:    acc = bus.in_valid && bus.in_sof;
      ACTIVE:  acc = bus.in_valid;
      DRAIN:   acc = bus.in_valid && (started_q || bus.in_sof);
      default: acc = 1'b0;
    endcase
    restart   = acc && bus.in_sof;
    sof_err_d = restart && !at_origin;
  end

  // Two-stage qualifier: flags follow the pixel, data is taken when valid.
  always_comb begin
    v1_d        = acc && is_interior;
    sof1_d      = acc && is_first_int;
    eol1_d      = acc && is_eol;
    out_valid_d = v1_q;
    out_sof_d   = sof1_q;
    out_eol_d   = eol1_q;
    out_data_d  = v1_q ? bus.dark_in : out_data_q;
  end

  // Running maximum of interior dark values; a new frame clears it.
  always_comb begin
    max_upd   = (v1_q && (bus.dark_in > max_run_q)) ? bus.dark_in : max_run_q;
    max_run_d = restart ? '0 : max_upd;
  end

  // Frame FSM. The drained frame's max is latched into pend so a frame
  // starting inside the drain can clear max_run without losing it.
  always_comb begin
    state_d      = state_q;
    drain_d      = drain_q;
    started_d    = started_q;
    pend_d       = pend_q;
    a_light_d    = a_light_q;
    frame_done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (restart) state_d = ACTIVE;
      end
      ACTIVE: begin
        if (acc && is_last) begin
          state_d   = DRAIN;
          drain_d   = '0;
          started_d = 1'b0;
        end
      end
      DRAIN: begin
        if (restart) started_d = 1'b1;
        if (drain_q == DRAIN_CAP) pend_d = max_upd;
        if (drain_q == DRAIN_END) begin
          a_light_d    = pend_q;
          frame_done_d = 1'b1;
          drain_d      = '0;
          started_d    = 1'b0;
          state_d      = (started_q || restart) ? ACTIVE : IDLE;
        end else begin
          drain_d = drain_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= IDLE;
      drain_q      <= '0;
      started_q    <= 1'b0;
      max_run_q    <= '0;
      pend_q       <= '0;
      a_light_q    <= '0;
      frame_done_q <= 1'b0;
      sof_err_q    <= 1'b0;
      v1_q         <= 1'b0;
      sof1_q       <= 1'b0;
      eol1_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_sof_q    <= 1'b0;
      out_eol_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      drain_q      <= drain_d;
      started_q    <= started_d;
      max_run_q    <= max_run_d;
      pend_q       <= pend_d;
      a_light_q    <= a_light_d;
      frame_done_q <= frame_done_d;
      sof_err_q    <= sof_err_d;
      v1_q         <= v1_d;
      sof1_q       <= sof1_d;
      eol1_q       <= eol1_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_sof_q    <= out_sof_d;
      out_eol_q    <= out_eol_d;
    end
  end

endmodule

// File: tb/tb_dark_channel_ctrl.sv
// Self-checking bench for dark_channel_ctrl on a 5x4 frame.
module tb_dark_channel_ctrl;

  localparam int W = 5;
  localparam int H = 4;

  typedef struct {
    int         due;
    logic [7:0] data;
    logic       sof;
    logic       eol;
  } beat_t;

  typedef struct {
    int due;
    int val;
  } al_t;

  logic clk;
  logic rst_n;

  dark_channel_ctrl_if #(.DW(8)) bus ();

  dark_channel_ctrl #(
    .IMG_W (W),
    .IMG_H (H),
    .DW    (8)
  ) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int edge_n  = 0;

  // Reference model: frame-level view of the stream.
  beat_t beat_q[$];
  int    fd_q[$];
  int    err_q[$];
  al_t   al_q[$];
  bit    m_open = 1'b0;
  int    m_pos  = 0;
  int    m_max  = 0;
  int    exp_alight = 0;
  logic       prev_v = 1'b0;
  logic [7:0] prev_d = '0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got %0d expected %0d", tag, edge_n, act, exp);
    end
  endtask

  task automatic model_reset();
    beat_q.delete();
    fd_q.delete();
    err_q.delete();
    al_q.delete();
    m_open     = 1'b0;
    m_pos      = 0;
    m_max      = 0;
    exp_alight = 0;
    prev_v     = 1'b0;
  endtask

  // Pixel sampled at edge S with dark value d appearing after it.
  task automatic model_px(input logic v, input logic s, input logic [7:0] d, input int S);
    int    x, y;
    beat_t b;
    al_t   a;
    if (!v) return;
    if (!(m_open || s)) return;
    if (s) begin
      if (m_open && m_pos != 0) err_q.push_back(S);
      m_open = 1'b1;
      m_pos  = 0;
      m_max  = 0;
    end
    x = m_pos % W;
    y = m_pos / W;
    if (x >= 2 && y >= 2) begin
      b.due  = S + 1;
      b.data = d;
      b.sof  = (x == 2 && y == 2);
      b.eol  = (x == W - 1);
      beat_q.push_back(b);
      if (int'(d) > m_max) m_max = int'(d);
    end
    m_pos++;
    if (m_pos == W * H) begin
      fd_q.push_back(S + 2);
      a.due = S + 2;
      a.val = m_max;
      al_q.push_back(a);
      m_open = 1'b0;
      m_pos  = 0;
    end
  endtask

  task automatic check_outputs();
    logic exp_v, exp_fd, exp_err;
    exp_v = (beat_q.size() > 0) && (beat_q[0].due == edge_n);
    chk("out_valid", bus.out_valid, exp_v);
    if (exp_v) begin
      chk("out_data", bus.out_data, beat_q[0].data);
      chk("out_sof", bus.out_sof, beat_q[0].sof);
      chk("out_eol", bus.out_eol, beat_q[0].eol);
      void'(beat_q.pop_front());
    end
    exp_fd = (fd_q.size() > 0) && (fd_q[0] == edge_n);
    if (exp_fd) void'(fd_q.pop_front());
    chk("frame_done", bus.frame_done, exp_fd);
    exp_err = (err_q.size() > 0) && (err_q[0] == edge_n);
    if (exp_err) void'(err_q.pop_front());
    chk("sof_err", bus.sof_err, exp_err);
    while (al_q.size() > 0 && al_q[0].due <= edge_n) begin
      exp_alight = al_q[0].val;
      void'(al_q.pop_front());
    end
    chk("a_light", bus.a_light, exp_alight);
    chk("shift_en", bus.shift_en, bus.in_valid);
  endtask

  // One clock: check what the last edge produced, then drive the next pixel.
  task automatic step(input logic v, input logic s, input logic [7:0] d);
    @(posedge clk);
    edge_n++;
    @(negedge clk);
    check_outputs();
    if (prev_v) bus.dark_in = prev_d;
    bus.in_valid = v;
    bus.in_sof   = s;
    prev_v = v;
    prev_d = d;
    model_px(v, s, d, edge_n + 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'($urandom));
  endtask

  // Raster pixels by index, sof on the first; dark = centre x + 10*y + off.
  task automatic send_range(input int first, input int last, input int off, input int gap);
    for (int i = first; i <= last; i++) begin
      int x, y;
      logic [7:0] d;
      x = i % W;
      y = i / W;
      d = (x >= 1 && y >= 1) ? 8'((x - 1) + 10 * (y - 1) + off) : 8'($urandom);
      step(1'b1, (i == first), d);
      for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 8'($urandom));
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_out_data"}, bus.out_data, 0);
    chk({tag, "_out_sof"}, bus.out_sof, 0);
    chk({tag, "_out_eol"}, bus.out_eol, 0);
    chk({tag, "_frame_done"}, bus.frame_done, 0);
    chk({tag, "_a_light"}, bus.a_light, 0);
    chk({tag, "_sof_err"}, bus.sof_err, 0);
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    bus.dark_in  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    idle(3);

    // Continuous frame.
    send_range(0, W * H - 1, 0, 0);
    idle(4);
    chk("a_light_cont", bus.a_light, 23);

    // Same frame, 3 idle cycles after each pixel.
    send_range(0, W * H - 1, 0, 3);
    idle(4);
    chk("a_light_gap", bus.a_light, 23);

    // Pixels without sof while idle are ignored.
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 8'($urandom));
    idle(3);

    // sof at (3,1) aborts; the restarted frame completes on its own values.
    send_range(0, 7, 90, 0);
    send_range(0, W * H - 1, 50, 0);
    idle(4);
    chk("a_light_abort", bus.a_light, 73);

    // Back-to-back frames.
    send_range(0, W * H - 1, 100, 0);
    send_range(0, W * H - 1, 0, 0);
    idle(4);
    chk("a_light_b2b", bus.a_light, 23);

    // Asynchronous reset with outputs in flight.
    send_range(0, 13, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    model_reset();
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    idle(3);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'($urandom));
    send_range(0, W * H - 1, 7, 0);
    idle(4);

    // Randomised stream with occasional aborts.
    for (int i = 0; i < 1500; i++) begin
      logic v, s;
      v = ($urandom_range(0, 9) < 7);
      if (!m_open) s = ($urandom_range(0, 3) == 0);
      else         s = ($urandom_range(0, 99) == 0);
      step(v, s, 8'($urandom));
    end
    idle(5);
    chk("pending_beats", beat_q.size(), 0);
    chk("pending_frame_done", fd_q.size(), 0);
    chk("pending_sof_err", err_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
